// File: rtl/alu32_pkg.sv
// Shared ALU definitions: datapath width and the left-shifter FSM state encoding.
package alu32_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {SL_IDLE, SL_SHIFT, SL_DONE} sl_state_t;

endpackage : alu32_pkg

// File: rtl/sl32_stage.sv
// One binary stage of the left shifter: optionally shifts or rotates by 2**amt_log2.
module sl32_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   in,
    input  logic               en,
    input  logic               rotate,
    input  logic [SHAMT_W-1:0] amt_log2,
    output logic [WIDTH-1:0]   out
);

    logic [SHAMT_W-1:0] amt;
    logic [2*WIDTH-1:0] doubled;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        amt     = SHAMT_W'(1) << amt_log2;
        doubled = {in, in} << amt;
        out     = in;
        if (en) begin
            // The upper half of the shifted doubled word is the rotated operand.
            out = rotate ? doubled[2*WIDTH-1:WIDTH] : (in << amt);
        end
    end

endmodule : sl32_stage

// File: rtl/sl32_iter.sv
// Multi-cycle left shifter/rotator: one binary stage (16, 8, 4, 2, 1) per clock behind valid/ready ports.
module sl32_iter
    import alu32_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_rotate,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    localparam logic [SHAMT_W-1:0] LAST_STAGE = SHAMT_W'(SHAMT_W - 1);

    sl_state_t          state;
    logic [SHAMT_W-1:0] stage;
    logic [SHAMT_W-1:0] shamt_r;
    logic               rotate_r;
    logic [WIDTH-1:0]   acc;

    logic [SHAMT_W-1:0] stage_amt;
    logic               stage_en;
    logic [WIDTH-1:0]   stage_out;

    // Stage k handles the most significant remaining shamt bit first.
    assign stage_amt = LAST_STAGE - stage;
    assign stage_en  = shamt_r[stage_amt];

    sl32_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .in       (acc),
        .en       (stage_en),
        .rotate   (rotate_r),
        .amt_log2 (stage_amt),
        .out      (stage_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SL_IDLE;
            stage     <= '0;
            shamt_r   <= '0;
            rotate_r  <= 1'b0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                SL_IDLE: begin
                    if (in_valid && in_ready) begin
                        acc      <= in_data;
                        shamt_r  <= in_shamt;
                        rotate_r <= in_rotate;
                        stage    <= '0;
                        in_ready <= 1'b0;
                        state    <= SL_SHIFT;
                    end
                end
                SL_SHIFT: begin
                    acc <= stage_out;
                    if (stage == LAST_STAGE) begin
                        state <= SL_DONE;
                    end else begin
                        stage <= stage + SHAMT_W'(1);
                    end
                end
                SL_DONE: begin
                    // First DONE cycle publishes acc; the output then holds until taken.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= acc;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= SL_IDLE;
                    end
                end
                default: begin
                    state    <= SL_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule : sl32_iter
